// File: rtl/wb_ram_slave.sv
// Wishbone classic single-transfer RAM slave with programmable wait states.
// Define WB_RAM_ERR_EN to add wbs_err_o, which flags out-of-range accesses.
module wb_ram_slave #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
`ifdef WB_RAM_ERR_EN
   output logic        wbs_err_o,
`endif
   output logic        wbs_ack_o
);

   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

   typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] adr_q, dat_q;
   logic        we_q;
   logic [3:0]  sel_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] cur_adr, cur_dat, offset;
   logic        cur_we, in_range, enter_ack, wr_en, ack_d;
   logic [3:0]  cur_sel;
   logic [AW-1:0] idx;
   logic [31:0] dat_d;

   // With zero wait states the commit happens on the accept edge, before the latches load.
   always_comb begin
      cur_adr = (state_q == StIdle) ? wbs_adr_i : adr_q;
      cur_dat = (state_q == StIdle) ? wbs_dat_i : dat_q;
      cur_we  = (state_q == StIdle) ? wbs_we_i  : we_q;
      cur_sel = (state_q == StIdle) ? wbs_sel_i : sel_q;
      offset   = cur_adr - BASE_ADDR;
      in_range = offset < SPAN;
      idx      = offset[AW+1:2];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (wbs_stb_i && wbs_cyc_i) begin
               cnt_d   = 4'(WAIT_STATES);
               state_d = (WAIT_STATES == 0) ? StAck : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (!wbs_cyc_i) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == 4'd1) begin
               state_d = StAck;
            end
         end
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      enter_ack = (state_d == StAck) && (state_q != StAck);
      wr_en     = enter_ack && cur_we && in_range;
`ifdef WB_RAM_ERR_EN
      ack_d     = enter_ack && in_range;
`else
      ack_d     = enter_ack;
`endif
      dat_d     = (enter_ack && !cur_we && in_range) ? mem[idx] : 32'h0;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
`ifdef WB_RAM_ERR_EN
         wbs_err_o <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wbs_ack_o <= ack_d;
         wbs_dat_o <= dat_d;
`ifdef WB_RAM_ERR_EN
         wbs_err_o <= enter_ack && !in_range;
`endif
         if (state_q == StIdle && wbs_stb_i && wbs_cyc_i) begin
            adr_q <= wbs_adr_i;
            dat_q <= wbs_dat_i;
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
         end
      end
   end

   // Storage has no reset; a reset edge only blocks a pending commit.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i && wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_sel[b]) mem[idx][8*b +: 8] <= cur_dat[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances (0, 1 and 3 wait states) checked each cycle
// against a transaction-level model, plus literal checks of key read values and latencies.
module tb_wb_ram_slave;

   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [3];
   logic        stb [3];
   logic        cyc [3];
   logic        we  [3];
   logic [3:0]  sel [3];
   logic [31:0] adr [3];
   logic [31:0] wdat[3];
   logic [31:0] rdat[3];
   logic        ack [3];
`ifdef WB_RAM_ERR_EN
   logic        err [3];
`endif

   function automatic int ws_of(input int d);
      case (d)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   function automatic logic [31:0] base_of(input int d);
      return (d == 1) ? 32'h0000_0400 : 32'h0000_0000;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      wb_ram_slave #(
         .DEPTH_WORDS(DEPTH),
         .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : 3),
         .BASE_ADDR  ((g == 1) ? 32'h0000_0400 : 32'h0000_0000)
      ) u_dut (
         .wb_clk_i (clk),
         .wb_rst_i (rst[g]),
         .wbs_adr_i(adr[g]),
         .wbs_dat_i(wdat[g]),
         .wbs_dat_o(rdat[g]),
         .wbs_we_i (we[g]),
         .wbs_sel_i(sel[g]),
         .wbs_stb_i(stb[g]),
         .wbs_cyc_i(cyc[g]),
`ifdef WB_RAM_ERR_EN
         .wbs_err_o(err[g]),
`endif
         .wbs_ack_o(ack[g])
      );
   end

   // Model state: memory image and the single outstanding response per instance.
   logic [31:0] mm [3][DEPTH];
   int          cyc_n = 0;
   bit          pend_v  [3];
   int          pend_cyc[3];
   logic [31:0] pend_dat[3];
   bit          pend_err[3];
   int          vectors = 0;
   int          miscompares = 0;
   bit          chk_en = 1'b0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(negedge clk) begin
      bit          hit;
      logic        e_ack, e_err;
      logic [31:0] e_dat;
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            hit   = pend_v[d] && (cyc_n == pend_cyc[d]);
            e_ack = hit && !pend_err[d];
            e_err = hit && pend_err[d];
            e_dat = e_ack ? pend_dat[d] : 32'h0;
            vectors++;
            if (ack[d] !== e_ack || rdat[d] !== e_dat) begin
               miscompares++;
               $display("FAIL cycle_check dut%0d cycle %0d: ack=%b dat=%h, required ack=%b dat=%h",
                        d, cyc_n, ack[d], rdat[d], e_ack, e_dat);
            end
`ifdef WB_RAM_ERR_EN
            vectors++;
            if (err[d] !== e_err) begin
               miscompares++;
               $display("FAIL err_check dut%0d cycle %0d: err=%b, required %b",
                        d, cyc_n, err[d], e_err);
            end
`else
            if (e_err) begin
               miscompares++;
               $display("FAIL model_err dut%0d cycle %0d: err expected without WB_RAM_ERR_EN",
                        d, cyc_n);
            end
`endif
            if (pend_v[d] && cyc_n >= pend_cyc[d]) pend_v[d] = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // mode: 0 normal, 1 hold stb through the ack-exit edge, 2 abort after one cycle,
   // 3 reset one cycle into the transfer. Called #1 after a rising edge.
   task automatic xfer(input int d, input logic [31:0] off, input logic w,
                       input logic [31:0] data, input logic [3:0] s, input int mode,
                       output logic [31:0] got, output int lat);
      bit         inr, done;
      int         idx;
      got  = 'x;
      lat  = 0;
      done = 1'b0;
      inr  = off < DEPTH * 4;
      idx  = int'(off >> 2) % DEPTH;
      adr[d] = base_of(d) + off; wdat[d] = data; we[d] = w; sel[d] = s;
      stb[d] = 1'b1; cyc[d] = 1'b1;
      pend_dat[d] = (!w && inr) ? mm[d][idx] : 32'h0;
`ifdef WB_RAM_ERR_EN
      pend_err[d] = !inr;
`else
      pend_err[d] = 1'b0;
`endif
      pend_cyc[d] = cyc_n + 1 + ws_of(d);
      pend_v[d]   = 1'b1;
      if (mode == 2) begin
         repeat (2) @(posedge clk);
         #1 cyc[d] = 1'b0; stb[d] = 1'b0; pend_v[d] = 1'b0;
         repeat (6) @(posedge clk);
         #1;
         return;
      end
      if (mode == 3) begin
         @(posedge clk);
         #1 rst[d] = 1'b1; pend_v[d] = 1'b0;
         @(posedge clk);
         #1 rst[d] = 1'b0; stb[d] = 1'b0; cyc[d] = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         return;
      end
      if (w && inr) begin
         for (int b = 0; b < 4; b++) if (s[b]) mm[d][idx][8*b +: 8] = data[8*b +: 8];
      end
      while (!done && lat < 25) begin
         @(posedge clk);
         #1;
         lat++;
         if (ack[d] === 1'b1) done = 1'b1;
`ifdef WB_RAM_ERR_EN
         if (err[d] === 1'b1) done = 1'b1;
`endif
      end
      got = rdat[d];
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout dut%0d off %h: no response in 25 cycles, required one", d, off);
      end
      if (mode == 1) begin
         @(posedge clk);
         #1;
      end
      stb[d] = 1'b0; cyc[d] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      int          lat;
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; stb[d] = 1'b0; cyc[d] = 1'b0; we[d] = 1'b0;
         sel[d] = 4'h0; adr[d] = '0; wdat[d] = '0; pend_v[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      @(posedge clk);
      #1;

      // One wait state: full and partial writes, ignored address bits, out of range.
      xfer(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, got, lat);
      chk("ws1_write_latency", 32'(lat), 32'd2);
      xfer(0, 32'h10, 1'b0, 32'h0, 4'hF, 0, got, lat);
      chk("ws1_read_data", got, 32'hDEADBEEF);
      chk("ws1_read_latency", 32'(lat), 32'd2);
      xfer(0, 32'h10, 1'b1, 32'h00AA0000, 4'b0100, 0, got, lat);
      xfer(0, 32'h10, 1'b0, 32'h0, 4'b0001, 0, got, lat);
      chk("partial_write", got, 32'hDEAABEEF);
      xfer(0, 32'h10, 1'b1, 32'hFFFFFFFF, 4'b0000, 0, got, lat);
      chk("sel0_acked_latency", 32'(lat), 32'd2);
      xfer(0, 32'h13, 1'b0, 32'h0, 4'h0, 0, got, lat);
      chk("sel0_no_change_low_bits", got, 32'hDEAABEEF);
      xfer(0, 32'h04, 1'b1, 32'h11223344, 4'hF, 0, got, lat);
      xfer(0, 32'h44, 1'b1, 32'h99999999, 4'hF, 0, got, lat);
      xfer(0, 32'h40, 1'b0, 32'h0, 4'hF, 0, got, lat);
      chk("oor_read_data", got, 32'h0);
      chk("oor_read_latency", 32'(lat), 32'd2);
      xfer(0, 32'h04, 1'b0, 32'h0, 4'hF, 0, got, lat);
      chk("oor_write_discarded", got, 32'h11223344);

      // Zero wait states, non-zero base: back-to-back reads, one holding stb past ack.
      xfer(1, 32'h0, 1'b1, 32'hA5A5A5A5, 4'hF, 0, got, lat);
      xfer(1, 32'h4, 1'b1, 32'h0F0F0F0F, 4'hF, 0, got, lat);
      xfer(1, 32'h0, 1'b0, 32'h0, 4'hF, 0, got, lat);
      chk("ws0_read0", got, 32'hA5A5A5A5);
      chk("ws0_latency", 32'(lat), 32'd1);
      xfer(1, 32'h4, 1'b0, 32'h0, 4'hF, 1, got, lat);
      chk("ws0_read4_hold", got, 32'h0F0F0F0F);
      xfer(1, 32'h0, 1'b0, 32'h0, 4'hF, 0, got, lat);
      chk("ws0_read0_again", got, 32'hA5A5A5A5);

      // Three wait states: abort, reset mid-wait, recovery.
      xfer(2, 32'h20, 1'b1, 32'hCAFEF00D, 4'hF, 0, got, lat);
      chk("ws3_latency", 32'(lat), 32'd4);
      xfer(2, 32'h20, 1'b1, 32'h12345678, 4'hF, 2, got, lat);
      xfer(2, 32'h20, 1'b0, 32'h0, 4'hF, 0, got, lat);
      chk("abort_no_write", got, 32'hCAFEF00D);
      xfer(2, 32'h30, 1'b1, 32'h5555AAAA, 4'hF, 0, got, lat);
      xfer(2, 32'h30, 1'b1, 32'h00000000, 4'hF, 3, got, lat);
      xfer(2, 32'h30, 1'b0, 32'h0, 4'hF, 0, got, lat);
      chk("reset_no_commit", got, 32'h5555AAAA);
      xfer(2, 32'h30, 1'b1, 32'h0000BEEF, 4'b0011, 0, got, lat);
      xfer(2, 32'h30, 1'b0, 32'h0, 4'hF, 0, got, lat);
      chk("after_reset_served", got, 32'h5555BEEF);

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_ram_slave.md
WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, at least 4.
REQ-002 SHALL have parameter WAIT_STATES, default 1: extra cycles inserted before ack; range 0..15.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
REQ-004 SHALL use one clock and a synchronous, active-high reset: wb_clk_i and wb_rst_i.
REQ-005 wb_clk_i  input  1  clock; all state updates on the rising edge.
REQ-006 wb_rst_i  input  1  synchronous active-high reset.
REQ-007 wbs_adr_i  input  32  byte address.
REQ-008 wbs_dat_i  input  32  write data.
REQ-009 wbs_dat_o  output  32  read data, registered.
REQ-010 wbs_we_i  input  1  1 = write, 0 = read.
REQ-011 wbs_sel_i  input  4  byte-lane enables; bit n covers bits [8n+7:8n].
REQ-012 wbs_stb_i  input  1  strobe.
REQ-013 wbs_cyc_i  input  1  cycle valid.
REQ-014 wbs_ack_o  output  1  transfer acknowledge, registered.

Function
REQ-015 SHALL implement Wishbone classic single transfers as a three-state FSM: IDLE, WAIT, ACK.
- IDLE with stb&cyc high at edge N: latch adr/dat/we/sel and load the wait counter with WAIT_STATES.
- If WAIT_STATES=0, go to ACK; otherwise go to WAIT.
REQ-016 In WAIT, the counter SHALL decrement each edge; the FSM SHALL go to ACK at the edge where the counter reads 1.
REQ-017 wbs_ack_o SHALL be high for exactly one cycle, in state ACK; ACK SHALL always return to IDLE.
- The request cycle's ack is high in the cycle following edge N+WAIT_STATES.
- A new request SHALL NOT be accepted before the cycle after ACK.
REQ-018 Word index SHALL be (adr - BASE_ADDR) >> 2; adr[1:0] are ignored.
- In range means adr - BASE_ADDR < DEPTH_WORDS*4, compared unsigned.
REQ-019 Write, in range: at the edge entering ACK, SHALL update only the lanes whose sel bit is 1; sel=0000 changes nothing but is still acked.
REQ-020 Read, in range: wbs_dat_o SHALL hold the full stored word during the ack cycle, regardless of sel.
REQ-021 wbs_dat_o SHALL be 0 whenever ack is low.
REQ-022 Abort: if cyc is low at any edge while in WAIT, the FSM SHALL return to IDLE with no write and no ack.
REQ-023 Out-of-range access with WB_RAM_ERR_EN undefined: SHALL ack normally; a read returns 0 and a write is discarded.
REQ-024 Memory contents SHALL NOT be altered by reset; uninitialised contents are undefined.

Reset
REQ-025 wb_rst_i high at an edge SHALL force state IDLE, counter 0, wbs_ack_o 0 and wbs_dat_o 0 (and wbs_err_o 0 when present).
REQ-026 Reset in WAIT or ACK SHALL cancel the transfer; a write not yet committed SHALL NOT commit.
REQ-027 Reset SHALL take priority over any simultaneous stb&cyc.

Configuration
REQ-028 Macro WB_RAM_ERR_EN, when defined, SHALL add port wbs_err_o (output, 1 bit).
- An out-of-range access follows the same latency but asserts wbs_err_o instead of wbs_ack_o, for one cycle.
- Read data SHALL be 0 and no write SHALL occur.
- In-range behaviour is unchanged.
REQ-029 When WB_RAM_ERR_EN is undefined, wbs_err_o SHALL not exist and REQ-023 applies.

Verification
REQ-030 WAIT_STATES=1: write 32'hDEADBEEF to 0x10 with sel=1111, then read 0x10 -> each ack exactly one cycle, 2 cycles after the request edge; read returns DEADBEEF.
REQ-031 Partial write: 0x10 holds 32'hDEADBEEF; write 32'h00AA0000 with sel=0100, then read 0x10 -> 32'hDEAABEEF.
REQ-032 WAIT_STATES=0: back-to-back reads of 0x0 and 0x4 with stb dropped after each ack -> each ack in the cycle after its request edge; no double ack.
REQ-033 Abort: WAIT_STATES=3, write 32'h12345678 to 0x20; drop cyc after 1 cycle; then read 0x20 -> no ack for the aborted write; read returns the previous contents.
REQ-034 Out of range: read at BASE_ADDR+DEPTH_WORDS*4 -> without the macro, ack with data 0; with WB_RAM_ERR_EN, err for one cycle, ack never asserted.
REQ-035 Reset mid-WAIT: WAIT_STATES=3 write, wb_rst_i high for 1 cycle during WAIT -> ack, err and dat_o at 0; memory unchanged; next request is served normally.
